// File: rtl/mac_pkg.sv
// Shared definitions for the MAC operand feeder.
// Holds default widths and the feeder state encoding.
package mac_pkg;

  localparam int DW_DEF   = 32;
  localparam int NMAX_DEF = 64;

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_STREAM = 2'd1,
    ST_WAIT   = 2'd2,
    ST_DONE   = 2'd3
  } feed_state_e;

endpackage

// File: rtl/mac_pair_buf.sv
// Operand pair buffer for the MAC feeder.
// One registered write port, one combinational read port.
module mac_pair_buf
  import mac_pkg::*;
#(
  parameter int DW   = DW_DEF,
  parameter int NMAX = NMAX_DEF,
  parameter int AW   = (NMAX > 1) ? $clog2(NMAX) : 1
) (
  input  logic            clk,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [2*DW-1:0] wdata,
  input  logic [AW-1:0]   raddr,
  output logic [2*DW-1:0] rdata
);

  logic [2*DW-1:0] mem [NMAX];

  // Contents are never reset; every entry is rewritten before it is read.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/mac_feeder.sv
// Loads NMAX operand pairs, streams them to a MAC without bubbles,
// then captures and holds the dot-product result.
module mac_feeder
  import mac_pkg::*;
#(
  parameter int DW   = DW_DEF,
  parameter int NMAX = NMAX_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ld_valid,
  output logic          ld_ready,
  input  logic [DW-1:0] ld_data,
  input  logic [DW-1:0] ld_weight,
  output logic [DW-1:0] mac_data,
  output logic [DW-1:0] mac_weight,
  output logic          mac_ena,
  input  logic          mac_cnt_c,
  input  logic [DW-1:0] mac_result,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [DW-1:0] res_data,
  output logic          err
);

  localparam int IW = $clog2(NMAX + 1);
  localparam int AW = (NMAX > 1) ? $clog2(NMAX) : 1;
  localparam logic [IW-1:0] LAST = IW'(NMAX - 1);

  feed_state_e     state;
  logic [IW-1:0]   idx;
  logic [2*DW-1:0] rd_pair;
  logic            wr_en;
  logic            at_last;

  assign ld_ready  = (state == ST_LOAD);
  assign mac_ena   = (state == ST_STREAM);
  assign res_valid = (state == ST_DONE);
  assign wr_en     = ld_valid & ld_ready;
  assign at_last   = (idx == LAST);

  // The MAC accumulates every cycle, so operands are forced to zero when idle.
  assign mac_data   = mac_ena ? rd_pair[2*DW-1:DW] : '0;
  assign mac_weight = mac_ena ? rd_pair[DW-1:0]    : '0;

  mac_pair_buf #(
    .DW   (DW),
    .NMAX (NMAX),
    .AW   (AW)
  ) u_buf (
    .clk   (clk),
    .we    (wr_en),
    .waddr (idx[AW-1:0]),
    .wdata ({ld_data, ld_weight}),
    .raddr (idx[AW-1:0]),
    .rdata (rd_pair)
  );

  // Sequencing: fill the buffer, stream it once, wait one cycle, hold result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_LOAD;
      idx   <= '0;
    end else begin
      unique case (state)
        ST_LOAD: begin
          if (wr_en) begin
            if (at_last) begin
              idx   <= '0;
              state <= ST_STREAM;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        ST_STREAM: begin
          if (at_last) begin
            idx   <= '0;
            state <= ST_WAIT;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        ST_WAIT: state <= ST_DONE;
        ST_DONE: if (res_ready) state <= ST_LOAD;
        default: state <= ST_LOAD;
      endcase
    end
  end

  // Result capture and sticky error on a missing or stray count-complete.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_data <= '0;
      err      <= 1'b0;
    end else begin
      if (state == ST_WAIT) begin
        if (mac_cnt_c) begin
          res_data <= mac_result;
        end else begin
          res_data <= '0;
          err      <= 1'b1;
        end
      end else if (mac_cnt_c) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mac_feeder.sv
// Bench for mac_feeder with a behavioural MAC and a pair-level model.
// Directed vectors plus a per-cycle compare against the model.
module tb_mac_feeder;

  localparam int DW = 32;
  localparam int N  = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ld_valid = 1'b0;
  logic          ld_ready;
  logic [DW-1:0] ld_data = '0;
  logic [DW-1:0] ld_weight = '0;
  logic [DW-1:0] mac_data;
  logic [DW-1:0] mac_weight;
  logic          mac_ena;
  logic          mac_cnt_c;
  logic [DW-1:0] mac_result;
  logic          res_valid;
  logic          res_ready = 1'b0;
  logic [DW-1:0] res_data;
  logic          err;

  always #5 clk = ~clk;

  mac_feeder #(.DW(DW), .NMAX(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ld_valid   (ld_valid),
    .ld_ready   (ld_ready),
    .ld_data    (ld_data),
    .ld_weight  (ld_weight),
    .mac_data   (mac_data),
    .mac_weight (mac_weight),
    .mac_ena    (mac_ena),
    .mac_cnt_c  (mac_cnt_c),
    .mac_result (mac_result),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .err        (err)
  );

  // Behavioural MAC: adds data*weight every cycle, counts enabled cycles,
  // flags completion after N enables and then clears itself.
  bit          stub = 1'b0;
  logic [31:0] acc;
  int          cnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      cnt <= 0;
    end else if (cnt == N) begin
      acc <= mac_data * mac_weight;
      cnt <= mac_ena ? 1 : 0;
    end else begin
      acc <= acc + mac_data * mac_weight;
      cnt <= cnt + (mac_ena ? 1 : 0);
    end
  end

  assign mac_cnt_c  = !stub && (cnt == N);
  assign mac_result = acc;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0d required=%0d at %0t",
               name, act, exp, $time);
    end
  endtask

  // Pair-level model: collected pairs, the vector being streamed, its sum.
  logic [31:0] cur_d[$];
  logic [31:0] cur_w[$];
  logic [31:0] exp_d[N];
  logic [31:0] exp_w[N];
  logic [31:0] exp_res = '0;
  logic [31:0] sum;
  int          spos = N;

  always @(negedge clk) begin
    if (!rst_n) begin
      cur_d.delete();
      cur_w.delete();
      spos = N;
    end else begin
      if (mac_ena) begin
        if (spos < N) begin
          chk("stream_data", mac_data, exp_d[spos]);
          chk("stream_weight", mac_weight, exp_w[spos]);
          spos++;
        end else begin
          chk("mac_ena_without_vector", 32'(mac_ena), 0);
        end
      end else begin
        chk("idle_data", mac_data, 0);
        chk("idle_weight", mac_weight, 0);
      end
      if (mac_ena || res_valid) chk("ld_ready_busy", 32'(ld_ready), 0);
      if (res_valid) chk("res_data_model", res_data, exp_res);
      if (ld_valid && ld_ready) begin
        cur_d.push_back(ld_data);
        cur_w.push_back(ld_weight);
        if (cur_d.size() == N) begin
          sum = '0;
          for (int i = 0; i < N; i++) begin
            exp_d[i] = cur_d[i];
            exp_w[i] = cur_w[i];
            sum = sum + cur_d[i] * cur_w[i];
          end
          exp_res = stub ? 32'd0 : sum;
          spos = 0;
          cur_d.delete();
          cur_w.delete();
        end
      end
    end
  end

  logic [31:0] vd[N];
  logic [31:0] vw[N];

  task automatic set_vec(input logic [31:0] d0, w0, d1, w1,
                         input logic [31:0] d2, w2, d3, w3);
    vd[0] = d0; vw[0] = w0;
    vd[1] = d1; vw[1] = w1;
    vd[2] = d2; vw[2] = w2;
    vd[3] = d3; vw[3] = w3;
  endtask

  task automatic send_pair(input logic [31:0] d, w);
    int n = 0;
    ld_valid  = 1'b1;
    ld_data   = d;
    ld_weight = w;
    @(negedge clk);
    while (!ld_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (n >= 100) chk("load_timeout", 32'(n), 0);
    @(posedge clk);
    #1;
    ld_valid  = 1'b0;
    ld_data   = '0;
    ld_weight = '0;
  endtask

  task automatic send_vec(input int gap);
    for (int i = 0; i < N; i++) begin
      send_pair(vd[i], vw[i]);
      if (gap > 0 && i < N - 1) begin
        repeat (gap) @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic wait_res(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!res_valid && lat < 40);
  endtask

  task automatic take_res();
    @(posedge clk);
    #1;
    res_ready = 1'b1;
    @(negedge clk);
    chk("ld_ready_in_handshake", 32'(ld_ready), 0);
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    @(negedge clk);
    chk("ld_ready_after_handshake", 32'(ld_ready), 1);
    chk("res_valid_after_handshake", 32'(res_valid), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int lat;

    #12;
    chk("rst_res_valid", 32'(res_valid), 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_mac_ena", 32'(mac_ena), 0);
    chk("rst_mac_data", mac_data, 0);
    chk("rst_mac_weight", mac_weight, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("ld_ready_after_reset", 32'(ld_ready), 1);
    @(posedge clk);
    #1;

    set_vec(1, 2, 3, 4, 5, 6, 7, 8);
    send_vec(0);
    wait_res(lat);
    chk("lat_b2b", 32'(lat), N + 2);
    chk("res_b2b", res_data, 100);
    chk("err_b2b", 32'(err), 0);
    take_res();

    send_vec(1);
    wait_res(lat);
    chk("lat_gapped", 32'(lat), N + 2);
    chk("res_gapped", res_data, 100);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_data", res_data, 100);
      chk("hold_valid", 32'(res_valid), 1);
      chk("hold_ld_ready", 32'(ld_ready), 0);
    end
    take_res();

    set_vec(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
            32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    send_vec(0);
    wait_res(lat);
    chk("lat_ones", 32'(lat), N + 2);
    chk("res_ones", res_data, 4);
    take_res();

    set_vec(1, 2, 3, 4, 5, 6, 7, 8);
    send_vec(0);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("pre_reset_entry2", mac_data, 5);
    rst_n = 1'b0;
    #1;
    chk("arst_mac_ena", 32'(mac_ena), 0);
    chk("arst_mac_data", mac_data, 0);
    chk("arst_mac_weight", mac_weight, 0);
    chk("arst_res_valid", 32'(res_valid), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("ld_ready_after_abort", 32'(ld_ready), 1);
    chk("mac_ena_after_abort", 32'(mac_ena), 0);
    @(posedge clk);
    #1;
    send_vec(0);
    wait_res(lat);
    chk("lat_after_abort", 32'(lat), N + 2);
    chk("res_after_abort", res_data, 100);
    chk("err_after_abort", 32'(err), 0);
    take_res();

    stub = 1'b1;
    set_vec(2, 3, 4, 5, 6, 7, 8, 9);
    send_vec(0);
    wait_res(lat);
    chk("lat_stub", 32'(lat), N + 2);
    chk("res_stub", res_data, 0);
    chk("err_stub", 32'(err), 1);
    take_res();
    chk("err_sticky", 32'(err), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
